// File: rtl/door_pkg.sv
// Shared door-reporter types: event-kind codes, FSM state encoding and build-time defaults.
// Defaults for N_EX/N_IN/WORDLEN can be overridden on the command line.
`ifndef N_EX
`define N_EX 2
`endif
`ifndef N_IN
`define N_IN 1
`endif
`ifndef WORDLEN
`define WORDLEN 4
`endif

package door_pkg;

  typedef enum logic [1:0] {
    EV_ENTER_A = 2'b00,
    EV_EXIT_A  = 2'b01,
    EV_ENTER_B = 2'b10,
    EV_EXIT_B  = 2'b11
  } ev_kind_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  localparam int unsigned FIELDS_PER_DOOR = 4;

endpackage

// File: rtl/door_reporter_if.sv
// Report channel between the door reporter and the system monitor (valid/ready handshake).
interface door_reporter_if #(
  parameter int unsigned SYS_W = 4 * `WORDLEN * (`N_EX + `N_IN)
);
  logic             sys_valid;
  logic             sys_ready;
  logic [SYS_W-1:0] system;

  modport master (output sys_valid, output system, input sys_ready);
  modport slave  (input sys_valid, input system, output sys_ready);
endinterface

// File: rtl/door_counter.sv
// Four per-door event accumulators with epoch clear; saturating when DOOR_REPORTER_SAT_EN
// is defined, otherwise wrapping modulo 2^WORDLEN.
module door_counter
  import door_pkg::*;
#(
  parameter int unsigned WORDLEN = `WORDLEN
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clr,
  input  logic                                 ev_valid,
  input  logic [1:0]                           ev_kind,
  output logic [FIELDS_PER_DOOR*WORDLEN-1:0]   cnt,
  output logic                                 sat_hit_c
);

  logic [WORDLEN-1:0] acc [FIELDS_PER_DOOR];
  logic [FIELDS_PER_DOOR-1:0] hit;

`ifdef DOOR_REPORTER_SAT_EN
  localparam logic [WORDLEN-1:0] CNT_MAX = '1;
`endif

  always_comb begin
    hit = '0;
    for (int k = 0; k < int'(FIELDS_PER_DOOR); k++) begin
      hit[k] = ev_valid && (ev_kind == 2'(k));
    end
  end

  // Clear takes priority; an event in the clear cycle starts the new epoch at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(FIELDS_PER_DOOR); k++) acc[k] <= '0;
    end else begin
      for (int k = 0; k < int'(FIELDS_PER_DOOR); k++) begin
        if (clr) begin
          acc[k] <= hit[k] ? WORDLEN'(1) : '0;
`ifdef DOOR_REPORTER_SAT_EN
        end else if (hit[k] && (acc[k] != CNT_MAX)) begin
`else
        end else if (hit[k]) begin
`endif
          acc[k] <= acc[k] + WORDLEN'(1);
        end
      end
    end
  end

`ifdef DOOR_REPORTER_SAT_EN
  assign sat_hit_c = ev_valid && !clr && (acc[ev_kind] == CNT_MAX);
`else
  assign sat_hit_c = 1'b0;
`endif

  assign cnt = {acc[EV_ENTER_A], acc[EV_EXIT_A], acc[EV_ENTER_B], acc[EV_EXIT_B]};

endmodule

// File: rtl/door_reporter.sv
// Epoch-based door event reporter: counts per-door events and hands a snapshot to the monitor
// over a valid/ready channel. Optional saturation via macro DOOR_REPORTER_SAT_EN.
module door_reporter
  import door_pkg::*;
#(
  parameter int unsigned N_EX    = `N_EX,
  parameter int unsigned N_IN    = `N_IN,
  parameter int unsigned WORDLEN = `WORDLEN
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_EX-1:0]     ev_valid,
  input  logic [2*N_EX-1:0]   ev_kind,
  input  logic                epoch_tick,
  door_reporter_if.master     bus,
  output logic                sat
);

  localparam int unsigned DOOR_W = FIELDS_PER_DOOR * WORDLEN;
  localparam int unsigned EX_W   = DOOR_W * N_EX;
  localparam int unsigned SYS_W  = DOOR_W * (N_EX + N_IN);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic              snap_c;
  logic [EX_W-1:0]   acc_flat;
  logic [EX_W-1:0]   sys_ex;
  logic [N_EX-1:0]   sat_hits;

  for (genvar g = 0; g < int'(N_EX); g++) begin : g_door
    door_counter #(.WORDLEN(WORDLEN)) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (snap_c),
      .ev_valid  (ev_valid[g]),
      .ev_kind   (ev_kind[2*g +: 2]),
      .cnt       (acc_flat[DOOR_W*g +: DOOR_W]),
      .sat_hit_c (sat_hits[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  // A tick seen while FULL (including the handshake cycle) is deferred to the first EMPTY cycle.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    snap_c  = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (epoch_tick || pend_q) begin
          snap_c  = 1'b1;
          pend_d  = 1'b0;
          state_d = ST_FULL;
        end
      end
      ST_FULL: begin
        if (epoch_tick)    pend_d  = 1'b1;
        if (bus.sys_ready) state_d = ST_EMPTY;
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_ex <= '0;
      sat    <= 1'b0;
    end else begin
      if (snap_c)    sys_ex <= acc_flat;
      if (|sat_hits) sat    <= 1'b1;
    end
  end

  assign bus.sys_valid = (state_q == ST_FULL);
  assign bus.system    = SYS_W'(sys_ex);

endmodule

// File: tb/tb_door_reporter.sv
// Directed bench for door_reporter (N_EX=2, N_IN=1, WORDLEN=4) with a queue-based report scoreboard.
module tb_door_reporter;
  import door_pkg::*;

  localparam int unsigned SYS_W = 48;

  typedef struct packed {
    logic [SYS_W-1:0] system;
    logic             sat;
  } exp_t;

`ifdef DOOR_REPORTER_SAT_EN
  localparam logic [SYS_W-1:0] SAT_RPT  = 48'h0000_0000_F000;
  localparam logic             SAT_FLAG = 1'b1;
`else
  localparam logic [SYS_W-1:0] SAT_RPT  = 48'h0000_0000_4000;
  localparam logic             SAT_FLAG = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [1:0] ev_valid;
  logic [3:0] ev_kind;
  logic       epoch_tick;
  logic       sat;

  int tests;
  int fails;
  exp_t exp_q [$];

  door_reporter_if #(.SYS_W(SYS_W)) bus ();

  door_reporter #(.N_EX(2), .N_IN(1), .WORDLEN(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_valid   (ev_valid),
    .ev_kind    (ev_kind),
    .epoch_tick (epoch_tick),
    .bus        (bus.master),
    .sat        (sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [SYS_W-1:0] act, input logic [SYS_W-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Inputs change just after the rising edge and are sampled by the next one.
  task automatic step(input logic [1:0] v, input logic [3:0] k, input logic t, input logic r);
    ev_valid      = v;
    ev_kind       = k;
    epoch_tick    = t;
    bus.sys_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [SYS_W-1:0] s, input logic f);
    exp_t e;
    e.system = s;
    e.sat    = f;
    exp_q.push_back(e);
  endtask

  // Monitor: every accepted report is compared against the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && bus.sys_valid && bus.sys_ready) begin
      exp_t e;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL report_unexpected: got %h expected none", bus.system);
      end else begin
        e = exp_q.pop_front();
        if (bus.system !== e.system || sat !== e.sat) begin
          fails++;
          $display("FAIL report: got %h sat %b expected %h sat %b", bus.system, sat, e.system, e.sat);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    ev_valid = '0;
    ev_kind = '0;
    epoch_tick = 1'b0;
    bus.sys_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",  48'(bus.sys_valid), 48'd0);
    check("rst_system", bus.system,          48'd0);
    check("rst_sat",    48'(sat),            48'd0);
    rst_n = 1'b1;
    step(2'b00, 4'b0000, 1'b0, 1'b0);

    // Basic epoch: door0 enterA x3 + exitA x1, door1 enterB x2.
    step(2'b11, 4'b1000, 1'b0, 1'b0);
    step(2'b11, 4'b1000, 1'b0, 1'b0);
    step(2'b01, 4'b0000, 1'b0, 1'b0);
    step(2'b01, 4'b0001, 1'b0, 1'b0);
    check("pre_tick_valid", 48'(bus.sys_valid), 48'd0);
    step(2'b00, 4'b0000, 1'b1, 1'b0);
    push(48'h0000_0020_3100, 1'b0);
    check("tick_latency_valid", 48'(bus.sys_valid), 48'd1);

    // Back-pressure: report must hold steady while ready is low.
    for (int i = 0; i < 5; i++) begin
      check("hold_valid",  48'(bus.sys_valid), 48'd1);
      check("hold_system", bus.system, 48'h0000_0020_3100);
      step(2'b00, 4'b0000, 1'b0, 1'b0);
    end
    step(2'b00, 4'b0000, 1'b0, 1'b1);
    check("accept_valid_drop", 48'(bus.sys_valid), 48'd0);

    // Tick while FULL is deferred; events keep counting in the open epoch.
    step(2'b00, 4'b0000, 1'b1, 1'b0);
    push(48'd0, 1'b0);
    step(2'b01, 4'b0000, 1'b1, 1'b0);
    step(2'b01, 4'b0000, 1'b0, 1'b0);
    step(2'b00, 4'b0000, 1'b0, 1'b1);
    check("pending_gap_valid", 48'(bus.sys_valid), 48'd0);
    step(2'b00, 4'b0000, 1'b0, 1'b0);
    push(48'h0000_0000_2000, 1'b0);
    check("pending_snap_valid", 48'(bus.sys_valid), 48'd1);
    check("pending_snap_system", bus.system, 48'h0000_0000_2000);
    step(2'b00, 4'b0000, 1'b0, 1'b1);

    // Event coincident with a snapshot belongs to the next epoch.
    step(2'b10, 4'b1100, 1'b1, 1'b0);
    push(48'd0, 1'b0);
    check("coincide_snap_system", bus.system, 48'd0);
    step(2'b00, 4'b0000, 1'b0, 1'b1);
    step(2'b00, 4'b0000, 1'b1, 1'b0);
    push(48'h0000_0001_0000, 1'b0);
    check("coincide_next_system", bus.system, 48'h0000_0001_0000);
    step(2'b00, 4'b0000, 1'b0, 1'b1);

    // Overflow: 20 enterA events on door0 in one epoch.
    for (int i = 0; i < 20; i++) step(2'b01, 4'b0000, 1'b0, 1'b0);
    step(2'b00, 4'b0000, 1'b1, 1'b0);
    push(SAT_RPT, SAT_FLAG);
    check("ovf_system", bus.system, SAT_RPT);
    check("ovf_sat", 48'(sat), 48'(SAT_FLAG));
    step(2'b00, 4'b0000, 1'b0, 1'b1);

    // Reset while FULL with counts pending: report and counts are discarded.
    step(2'b11, 4'b0000, 1'b0, 1'b0);
    step(2'b00, 4'b0000, 1'b1, 1'b0);
    step(2'b11, 4'b1001, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midreset_valid",  48'(bus.sys_valid), 48'd0);
    check("midreset_system", bus.system, 48'd0);
    check("midreset_sat",    48'(sat), 48'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2'b00, 4'b0000, 1'b0, 1'b0);
    check("post_reset_idle_valid", 48'(bus.sys_valid), 48'd0);
    step(2'b00, 4'b0000, 1'b1, 1'b0);
    push(48'd0, 1'b0);
    check("post_reset_valid", 48'(bus.sys_valid), 48'd1);
    check("post_reset_system", bus.system, 48'd0);
    step(2'b00, 4'b0000, 1'b0, 1'b1);
    step(2'b00, 4'b0000, 1'b0, 1'b0);

    check("scoreboard_drained", 48'(exp_q.size()), 48'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/door_reporter.md
DOOR_REPORTER -- requirements
Module: door_reporter

Interface
REQ-001 SHALL have parameter N_EX, default `N_EX, number of external doors (≥1).
REQ-002 SHALL have parameter N_IN, default `N_IN, number of internal doors; their fields are transmitted as zero.
REQ-003 SHALL have parameter WORDLEN, default `WORDLEN, counter width in bits.
REQ-004 SHALL have clk  input  1  sole clock, rising edge.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have ev_valid  input  N_EX  per-door event strobe, one event per door per cycle.
REQ-007 SHALL have ev_kind  input  2*N_EX  per-door code, door g at [2g+1:2g]: 00 enterA, 01 exitA, 10 enterB, 11 exitB.
REQ-008 SHALL have epoch_tick  input  1  closes the current epoch.
REQ-009 SHALL have sys_valid  output  1  report available.
REQ-010 SHALL have sys_ready  input  1  monitor accepts the report when sys_valid && sys_ready.
REQ-011 SHALL have system  output  4*WORDLEN*(N_EX+N_IN)  packed report; internal doors in the upper bits, external doors in the lower bits; external door g at [4*WORDLEN*(g+1)-1 : 4*WORDLEN*g] = {enteredA, exitedA, enteredB, exitedB}, MSB first.
REQ-012 SHALL have sat  output  1  sticky saturation flag (see Configuration).

Function
REQ-013 SHALL keep four WORDLEN accumulators per external door and add 1 to the accumulator selected by ev_kind on each cycle where ev_valid[g]=1.
REQ-014 SHALL run a two-state FSM: EMPTY (sys_valid=0) and FULL (sys_valid=1).
REQ-015 In EMPTY, on epoch_tick or a pending tick, SHALL copy all accumulators into the system register, clear the accumulators and go to FULL; sys_valid rises the cycle after the tick (latency 1).
REQ-016 An event in the same cycle as a snapshot SHALL be counted in the new epoch (accumulator loads 1), not in the snapshot.
REQ-017 In FULL, system and sys_valid SHALL stay stable until the handshake; on the handshake the FSM returns to EMPTY.
REQ-018 An epoch_tick while FULL SHALL set a pending flag and SHALL NOT clear the accumulators; counting continues.
REQ-019 With pending set, the snapshot SHALL occur in the cycle after the handshake (the first EMPTY cycle), after which pending clears; further ticks while pending set are merged.
REQ-020 A tick coincident with the handshake SHALL count as a tick while FULL (REQ-018).
REQ-021 Internal-door fields of system SHALL always be zero.

Reset
REQ-022 While rst_n=0: FSM in EMPTY, sys_valid=0, system=0, accumulators=0, pending=0, sat=0.
REQ-023 Reset asserted mid-epoch or while FULL SHALL discard the report and all counts without a handshake.

Configuration
REQ-024 With macro DOOR_REPORTER_SAT_EN defined, accumulators SHALL saturate at 2^WORDLEN-1, and sat SHALL set on any attempted increment at maximum and stay set until reset.
REQ-025 Without DOOR_REPORTER_SAT_EN, accumulators SHALL wrap modulo 2^WORDLEN (consistent with the monitor's modular arithmetic), and sat SHALL be tied 0.

Structure
REQ-026 The event-kind codes and FSM state encoding SHALL reside in a shared package door_pkg.
REQ-027 Each per-door accumulator set SHALL be one sub-module door_counter (four counters, clear, saturation option) instantiated N_EX times by generate.

Verification (N_EX=2, N_IN=1, WORDLEN=4)
REQ-028 Door0 gets enterA ×3 and exitA ×1, door1 gets enterB ×2, then tick -> next cycle sys_valid=1, door0 field=16'h3100, door1 field=16'h0020, internal field=0.
REQ-029 sys_ready held 0 for 5 cycles -> system and sys_valid stable throughout; ready=1 -> sys_valid=0 next cycle.
REQ-030 Tick while FULL, plus 2 door0 enterA events before accept -> second report with door0 enterA=2 one cycle after the handshake.
REQ-031 Tick and door1 exitB in the same cycle -> exitB absent from this report and exitB=1 in the next report.
REQ-032 20 door0 enterA events then tick -> enterA=15 with sat=1 when DOOR_REPORTER_SAT_EN is defined; enterA=4 with sat=0 when it is not.
REQ-033 rst_n pulsed low while FULL -> sys_valid=0 immediately; a new tick with no events -> report of all zeros.
